// File: rtl/shift_pkg.sv
// Shared constants, command encodings and FSM state type for the shift sequencer.
package shift_pkg;

    localparam int WIDTH    = 32;
    localparam int STEP_MAX = 8;

    // Command encodings; every other value is a pass-through.
    localparam logic [3:0] CMD_LSL = 4'd0;
    localparam logic [3:0] CMD_LSR = 4'd1;
    localparam logic [3:0] CMD_ASR = 4'd2;
    localparam logic [3:0] CMD_ROR = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Total number of positions an operation will move.
    // Linear shifts saturate at the word width, rotates are taken modulo 32,
    // and pass-through moves nothing.
    function automatic logic [5:0] eff_amount(input logic [3:0]  cmd,
                                              input logic [31:0] amt);
        logic [5:0] n;
        n = 6'd0;
        case (cmd)
            CMD_LSL, CMD_LSR, CMD_ASR: begin
                if (amt > 32'd32) n = 6'd32;
                else              n = amt[5:0];
            end
            CMD_ROR: n = {1'b0, amt[4:0]};
            default: n = 6'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..8 positions with carry-out.
module shift_step
    import shift_pkg::*;
(
    input  logic [31:0] data,
    input  logic [3:0]  k,
    input  logic [3:0]  command,
    output logic [31:0] result,
    output logic        cout
);

    // Widened operands: the extra bit catches the last bit moved out.
    logic [32:0]        lsl_w;
    logic [32:0]        lsr_w;
    logic signed [32:0] asr_w;
    logic [31:0]        ror_w;
    logic [5:0]         ror_back;

    // Compute every flavour in parallel, then pick by command.
    always_comb begin
        lsl_w    = {1'b0, data} << k;
        lsr_w    = {data, 1'b0} >> k;
        asr_w    = $signed({data, 1'b0}) >>> k;
        ror_back = 6'd32 - {2'b00, k};
        // A shift by 32 of a 32-bit value yields zero, so k=0 rotates by nothing.
        ror_w    = (data >> k) | (data << ror_back);

        result = data;
        cout   = 1'b0;
        case (command)
            CMD_LSL: begin
                result = lsl_w[31:0];
                cout   = lsl_w[32];
            end
            CMD_LSR: begin
                result = lsr_w[32:1];
                cout   = lsr_w[0];
            end
            CMD_ASR: begin
                // Bit 31 of the working word is never disturbed by ASR, so
                // it always equals the sign bit latched at accept.
                result = asr_w[32:1];
                cout   = asr_w[0];
            end
            CMD_ROR: begin
                result = ror_w;
                cout   = (k != 4'd0) ? ror_w[31] : 1'b0;
            end
            default: begin
                result = data;
                cout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: moves up to 8 positions per cycle until done.
//
// Handshake: start is sampled only while IDLE on a rising edge with reset
// high; that edge latches in/command/shiftVal. busy is high in RUN and DONE,
// done is a single-cycle pulse in DONE, and out/carry hold the last
// completed result until the next DONE entry or reset. start is ignored
// while busy; nothing is queued.
module shift_seq
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  command,
    input  logic [31:0] in,
    input  logic [31:0] shiftVal,
    output logic [31:0] out,
    output logic        carry,
    output logic        busy,
    output logic        done,
    output state_t      dbg_state
);

    state_t      state_q, state_d;
    logic [31:0] work_q,  work_d;
    logic [5:0]  rem_q,   rem_d;
    logic [3:0]  cmd_q,   cmd_d;
    logic [31:0] out_q,   out_d;
    logic        carry_q, carry_d;

    logic [3:0]  step_k;
    logic [5:0]  rem_after;
    logic [31:0] step_result;
    logic        step_cout;

    // Positions applied this cycle and what remains afterwards.
    always_comb begin
        if (rem_q > 6'(STEP_MAX)) step_k = 4'(STEP_MAX);
        else                      step_k = rem_q[3:0];
        rem_after = rem_q - {2'b00, step_k};
    end

    shift_step u_step (
        .data    (work_q),
        .k       (step_k),
        .command (cmd_q),
        .result  (step_result),
        .cout    (step_cout)
    );

    // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        cmd_d   = cmd_q;
        out_d   = out_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = in;
                    cmd_d   = command;
                    rem_d   = eff_amount(command, shiftVal);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // n=0 still spends one cycle with a zero-position step.
                work_d = step_result;
                rem_d  = rem_after;
                if (rem_after == 6'd0) begin
                    out_d   = step_result;
                    carry_d = step_cout;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            cmd_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            cmd_q   <= cmd_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out       = out_q;
    assign carry     = carry_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign dbg_state = state_q;

endmodule
